// File: rtl/tensor_serializer.sv
// tensor_serializer: snapshots a tensor on start and streams it one element
// per valid/ready transfer. Optional: TENSOR_SER_SKIP_ZERO_EN skips zeros.
module tensor_serializer #(
   parameter int ELEMENTS = 9,
   parameter int WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ELEMENTS*WIDTH-1:0] tensor_in,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          element,
   output logic [3:0]                idx,
   output logic                      busy,
   output logic                      done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [3:0] LAST = 4'(ELEMENTS - 1);

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] snap [ELEMENTS];
   logic [WIDTH-1:0] cur;
   logic             zero;
   logic             adv;

   assign cur = snap[cnt];

`ifdef TENSOR_SER_SKIP_ZERO_EN
   assign zero = (state == S_STREAM) && (cur == '0);
`else
   assign zero = 1'b0;
`endif

   // outputs are decoded from registered state only
   always_comb begin
      out_valid = (state == S_STREAM) && !zero;
      element   = out_valid ? cur : '0;
      idx       = out_valid ? cnt : '0;
      busy      = (state == S_STREAM) || (state == S_DONE);
      done      = (state == S_DONE);
      adv       = (out_valid && out_ready) || zero;
   end

   // FSM, counter and snapshot register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         for (int k = 0; k < ELEMENTS; k++)
            snap[k] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int k = 0; k < ELEMENTS; k++)
                     snap[k] <= tensor_in[WIDTH*k +: WIDTH];
                  cnt   <= '0;
                  state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (adv) begin
                  if (cnt == LAST)
                     state <= S_DONE;
                  else
                     cnt <= cnt + 4'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tensor_serializer.sv
// Scoreboard bench for tensor_serializer: expected elements are queued when
// a transfer is started and popped as the consumer accepts them.
module tb_tensor_serializer;

   localparam int N = 9;
   localparam int W = 16;
   localparam int TW = N * W;

   logic          clk = 0;
   logic          reset = 1;
   logic          start = 0;
   logic [TW-1:0] tensor_in = '0;
   logic          out_ready = 0;
   logic          out_valid;
   logic [W-1:0]  element;
   logic [3:0]    idx;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int vld_cnt = 0;
   logic [19:0]   q [$];
   logic [TW-1:0] recon;

   tensor_serializer #(.ELEMENTS(N), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .tensor_in(tensor_in), .out_ready(out_ready),
      .out_valid(out_valid), .element(element), .idx(idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [TW-1:0] got,
                      input logic [TW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // consumer model: load path reconstructs the tensor, scoreboard checks
   always @(negedge clk) begin
      if (!reset) begin
         if (done) done_cnt++;
         if (out_valid) vld_cnt++;
         if (out_valid && out_ready) begin
            recon[W*idx +: W] = element;
            if (q.size() == 0)
               chk("sb_empty", 1, 0);
            else
               chk("sb_elem", TW'({idx, element}), TW'(q.pop_front()));
         end
      end
   end

   function automatic logic [TW-1:0] seq_tensor();
      logic [TW-1:0] t;
      for (int k = 0; k < N; k++) t[W*k +: W] = 16'h1000 + 16'(k);
      return t;
   endfunction

   task automatic push_tensor(input logic [TW-1:0] t);
      logic [W-1:0] e;
      for (int k = 0; k < N; k++) begin
         e = t[W*k +: W];
`ifdef TENSOR_SER_SKIP_ZERO_EN
         if (e != '0)
`endif
         q.push_back({4'(k), e});
      end
   endtask

   // leaves the bench #1 into cycle 1 (start sampled at the end of cycle 0)
   task automatic start_xfer(input logic [TW-1:0] t);
      push_tensor(t);
      @(posedge clk); #1;
      tensor_in = t;
      start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
      end
      chk("done_seen", TW'(seen), 1);
      @(posedge clk); #1;
   endtask

   logic [TW-1:0] t;
   int d0, v0, ev;

   initial begin
      #12;
      chk("rst_valid", TW'(out_valid), 0);
      chk("rst_elem", TW'(element), 0);
      chk("rst_idx", TW'(idx), 0);
      chk("rst_busy", TW'(busy), 0);
      chk("rst_done", TW'(done), 0);
      reset = 0;

      // back-to-back, ready always high
      out_ready = 1;
      start_xfer(seq_tensor());
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         chk("b2b_valid", TW'(out_valid), TW'(c <= 9));
         chk("b2b_idx", TW'(idx), TW'(c <= 9 ? c - 1 : 0));
         chk("b2b_elem", TW'(element), TW'(c <= 9 ? 16'h1000 + c - 1 : 0));
         chk("b2b_done", TW'(done), TW'(c == 10));
         chk("b2b_busy", TW'(busy), TW'(c <= 10));
         @(posedge clk); #1;
      end
      chk("b2b_drain", TW'(q.size()), 0);

      // backpressure in cycles 3..5
      start_xfer(seq_tensor());
      for (int c = 1; c <= 14; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         @(negedge clk);
         ev = (c <= 2) ? c - 1 : (c <= 6) ? 2 : c - 4;
         chk("bp_valid", TW'(out_valid), TW'(c <= 12));
         if (c <= 12) chk("bp_idx", TW'(idx), TW'(ev));
         if (c <= 12) chk("bp_elem", TW'(element), TW'(16'h1000 + ev));
         chk("bp_done", TW'(done), TW'(c == 13));
         @(posedge clk); #1;
      end
      chk("bp_drain", TW'(q.size()), 0);

      // snapshot and start-while-busy
      out_ready = 1;
      d0 = done_cnt;
      v0 = vld_cnt;
      start_xfer(seq_tensor());
      for (int c = 1; c <= 14; c++) begin
         if (c == 4) begin tensor_in = '1; start = 1; end
         if (c == 5) start = 0;
         @(negedge clk);
         @(posedge clk); #1;
      end
      chk("snap_done", TW'(done_cnt - d0), 1);
      chk("snap_valid", TW'(vld_cnt - v0), 9);
      chk("snap_busy", TW'(busy), 0);
      chk("snap_drain", TW'(q.size()), 0);

      // reset during idx 5
      start_xfer(seq_tensor());
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c < 6) begin @(posedge clk); #1; end
      end
      chk("pre_rst_idx", TW'(idx), 5);
      #2 reset = 1;
      #1;
      chk("mid_rst_valid", TW'(out_valid), 0);
      chk("mid_rst_elem", TW'(element), 0);
      chk("mid_rst_idx", TW'(idx), 0);
      chk("mid_rst_busy", TW'(busy), 0);
      chk("mid_rst_done", TW'(done), 0);
      q.delete();
      d0 = done_cnt;
      @(posedge clk); #1;
      reset = 0;
      repeat (4) @(negedge clk);
      chk("rst_no_done", TW'(done_cnt - d0), 0);
      start_xfer(seq_tensor());
      @(negedge clk);
      chk("restart_idx", TW'(idx), 0);
      chk("restart_valid", TW'(out_valid), 1);
      @(posedge clk); #1;
      wait_done();
      chk("restart_drain", TW'(q.size()), 0);

      // reference model: random tensors, random ready
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < N; k++) t[W*k +: W] = 16'($urandom);
         recon = '0;
         out_ready = 1'($urandom_range(0, 1));
         start_xfer(t);
         wait_done();
`ifdef TENSOR_SER_SKIP_ZERO_EN
         chk("ref_drain", TW'(q.size()), 0);
`else
         chk("ref_recon", recon, t);
`endif
      end

      // sparse tensor: only elements 2 and 8 nonzero
      out_ready = 1;
      t = '0;
      t[W*2 +: W] = 16'hABCD;
      t[W*8 +: W] = 16'h0001;
      start_xfer(t);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
`ifdef TENSOR_SER_SKIP_ZERO_EN
         chk("sz_valid", TW'(out_valid), TW'(c == 3 || c == 9));
`else
         chk("sz_valid", TW'(out_valid), TW'(c <= 9));
`endif
         chk("sz_done", TW'(done), TW'(c == 10));
         @(posedge clk); #1;
      end
      chk("sz_drain", TW'(q.size()), 0);

      // all-zero tensor
      v0 = vld_cnt;
      start_xfer('0);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         chk("z_done", TW'(done), TW'(c == 10));
         @(posedge clk); #1;
      end
`ifdef TENSOR_SER_SKIP_ZERO_EN
      chk("z_valid", TW'(vld_cnt - v0), 0);
`else
      chk("z_valid", TW'(vld_cnt - v0), 9);
`endif
      chk("z_drain", TW'(q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tensor_serializer.md
# tensor_serializer

Streams a stored tensor out one element per transfer, in the exact element/index form that the tensor load path consumes: a 16-bit element, a 4-bit index, and a load strobe. On `start` it snapshots a 144-bit tensor (9 × 16-bit elements) and emits elements in index order under a valid/ready handshake. It sits between the register file's tensor read port and any element-wise consumer: another tensor register, the memory write path, or the ALU operand bus.

## Interface
Parameters:
- `ELEMENTS`, 9, number of elements per tensor (1..15).
- `WIDTH`, 16, bits per element.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: begin a transfer; honoured only in IDLE.
- `tensor_in`, in, ELEMENTS*WIDTH: source tensor; element k is `tensor_in[WIDTH*k +: WIDTH]`.
- `out_ready`, in, 1: consumer can accept the current element.
- `out_valid`, out, 1: `element`/`idx` are valid; drives the consumer's `load`.
- `element`, out, WIDTH: current element value.
- `idx`, out, 4: index of the current element.
- `busy`, out, 1: high in STREAM and DONE.
- `done`, out, 1: single-cycle pulse after the final element.

## Operation
- **Reset values** (all outputs): `out_valid`=0, `element`=0, `idx`=0, `busy`=0, `done`=0. The snapshot register and the index counter clear to 0, and the FSM goes to IDLE. Reset asserted mid-transfer aborts immediately; no `done` is produced.
- **FSM states:**
  - IDLE: `start`=1 latches `tensor_in` into the snapshot, sets the counter to 0, and moves to STREAM.
  - STREAM: `element` = snapshot element[counter]; `idx` = counter; `out_valid`=1.
    - A transfer occurs on a rising edge where `out_valid` && `out_ready`.
    - On a transfer with counter < ELEMENTS-1, the counter increments.
    - On a transfer with counter = ELEMENTS-1, the FSM moves to DONE.
    - With `out_ready`=0, `element`, `idx` and `out_valid` hold stable; no value may change while valid is high and the element is not yet accepted.
  - DONE: `done`=1 for one cycle, then the FSM returns to IDLE.
- `tensor_in` changes after the start edge have no effect on the transfer in progress.
- `start` in STREAM or DONE is ignored; it is neither queued nor used to restart.
- `element` and `idx` read 0 whenever `out_valid`=0.
- The counter never exceeds ELEMENTS-1; no wrap-around is possible.

## Timing
- Start edge at cycle 0: first `out_valid`=1 (idx 0) in cycle 1.
- With `out_ready` held high, one element is transferred per cycle: idx 0..ELEMENTS-1 in cycles 1..ELEMENTS.
- `done` is high in cycle ELEMENTS+1. `busy` is high in cycles 1..ELEMENTS+1.
- The earliest next accepted `start` is sampled on the edge ending cycle ELEMENTS+2 (first IDLE cycle).
- All outputs are registered or decoded from registered state only. There is no combinational path from `out_ready` or `start` to any output.

## Configuration
- **`TENSOR_SER_SKIP_ZERO_EN` defined:**
  - In STREAM, an element equal to 0 is not presented: `out_valid`=0 for that cycle, and the counter advances on the next edge regardless of `out_ready`.
  - Each zero element costs one cycle.
  - If the last element is zero, the FSM goes to DONE after skipping it.
  - An all-zero tensor produces no valid cycles; `done` pulses in cycle ELEMENTS+1.
  - The consumer must be reset or cleared before such a transfer.
- **Macro undefined:** every element is emitted, including zeros, as described above.

## Test plan
- **Back-to-back, ready always high.**
  - Stimulus: reset, then `start` with element k = 0x1000+k and `out_ready`=1.
  - Response: cycles 1..9 show idx 0..8 with elements 0x1000..0x1008 and valid=1; `done`=1 in cycle 10 only; `busy` low from cycle 11.
- **Backpressure.**
  - Stimulus: same tensor; `out_ready` low in cycles 3–5.
  - Response: idx 2 / 0x1002 held with valid high through cycle 5; idx 3 appears in cycle 7; `done` in cycle 13.
- **Snapshot and start-while-busy.**
  - Stimulus: change `tensor_in` to all 0xFFFF and pulse `start` at cycle 4.
  - Response: output is unchanged (still 0x100k); no restart; a single `done` pulse.
- **Reset mid-transfer.**
  - Stimulus: assert `reset` asynchronously during idx 5.
  - Response: all outputs 0 immediately; no `done`; a subsequent `start` streams from idx 0.
- **Reference model.**
  - Stimulus: feed the stream into the tensor load path (`load`=`out_valid`), then compare.
  - Response: the reconstructed 144-bit value equals the source; repeat with random tensors and random `out_ready`.
- **`TENSOR_SER_SKIP_ZERO_EN` on.**
  - Stimulus: tensor with only elements 2 and 8 nonzero (0xABCD, 0x0001).
  - Response: exactly two valid cycles (idx 2 in cycle 3, idx 8 in cycle 9); `done` in cycle 10. An all-zero tensor gives no valid cycles and `done` in cycle 10.
